// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 7-segment clock display driver:
// edit-field codes, special glyphs and decimal digit helpers.
package display_pkg;

  typedef enum logic [1:0] {
    FIELD_NONE = 2'd0,
    FIELD_HOUR = 2'd1,
    FIELD_MIN  = 2'd2,
    FIELD_SEC  = 2'd3
  } field_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // Tens digit of a 0..63 value; only 0..59 reach the decoder unmasked.
  function automatic logic [3:0] tens_of(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  // Ones digit of a 0..63 value.
  function automatic logic [3:0] ones_of(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD to active-high 7-segment pattern, bit 0 = segment a .. bit 6 = segment g.
// Codes 10..15 never occur for in-range fields and decode to blank.
module seg7_decoder (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup of the glyph for one decimal digit.
  always_comb begin
    seg = 7'h00;
    case (bcd)
      4'd0: seg = 7'h3F;
      4'd1: seg = 7'h06;
      4'd2: seg = 7'h5B;
      4'd3: seg = 7'h4F;
      4'd4: seg = 7'h66;
      4'd5: seg = 7'h6D;
      4'd6: seg = 7'h7D;
      4'd7: seg = 7'h07;
      4'd8: seg = 7'h7F;
      4'd9: seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/display_scan_driver.sv
// Time-multiplexed scan driver for an HHMMSS / HHMM 7-segment clock display.
// A strobed time value is held pending and only shown from the next frame
// boundary, so a frame never mixes two different times.
module display_scan_driver
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter int HOUR_LZB     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  time_valid,
  input  logic [4:0]            hour,
  input  logic [5:0]            minute,
  input  logic [5:0]            second,
  input  logic                  mode_12h,
  input  logic [1:0]            edit_field,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  frame_start
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = $clog2(BLINK_FRAMES) + 1;

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          tc;
  logic          frame_bnd;

  logic [4:0] pend_hour, disp_hour;
  logic [5:0] pend_min,  disp_min;
  logic [5:0] pend_sec,  disp_sec;

  logic [IW-1:0] pair;
  logic [IW-1:0] slot;
  logic [4:0]    hour_shown;
  logic          hour_ok;
  logic          pm;
  field_t        field;
  logic [5:0]    field_val;
  logic          field_ok;
  logic          upper;
  logic [3:0]    bcd;
  logic [6:0]    dec_seg;
  logic [6:0]    glyph;
  logic          dp;
  logic [NUM_DIGITS-1:0] sel_next;

  assign tc          = (presc == PW'(SCAN_DIV - 1));
  assign frame_bnd   = tc && (idx == IW'(NUM_DIGITS - 1));
  assign frame_start = frame_bnd;

  // Prescaler and digit index: one digit slot every SCAN_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (tc) begin
      presc <= '0;
      idx   <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Blink phase flips after every BLINK_FRAMES frame boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_bnd) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Two-stage time capture: strobe into pending, pending into display at frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_hour <= '0;
      pend_min  <= '0;
      pend_sec  <= '0;
      disp_hour <= '0;
      disp_min  <= '0;
      disp_sec  <= '0;
    end else begin
      if (frame_bnd) begin
        disp_hour <= pend_hour;
        disp_min  <= pend_min;
        disp_sec  <= pend_sec;
      end
      if (time_valid) begin
        pend_hour <= hour;
        pend_min  <= minute;
        pend_sec  <= second;
      end
    end
  end

  // Each pair of digits is one field; in 4-digit mode the seconds pair is absent.
  assign pair  = idx >> 1;
  assign slot  = (NUM_DIGITS == 6) ? pair : pair + 1'b1;
  assign upper = idx[0];

  // Hour as shown on the display, plus the PM flag for 12-hour mode.
  always_comb begin
    hour_ok    = (disp_hour <= 5'd23);
    hour_shown = disp_hour;
    if (mode_12h) begin
      if (disp_hour == 5'd0) begin
        hour_shown = 5'd12;
      end else if (disp_hour > 5'd12) begin
        hour_shown = disp_hour - 5'd12;
      end
    end
    pm = mode_12h && hour_ok && (disp_hour >= 5'd12);
  end

  // Select the field and its value for the digit currently being scanned.
  always_comb begin
    field     = FIELD_NONE;
    field_val = '0;
    field_ok  = 1'b1;
    if (slot == IW'(0)) begin
      field     = FIELD_SEC;
      field_val = disp_sec;
      field_ok  = (disp_sec <= 6'd59);
    end else if (slot == IW'(1)) begin
      field     = FIELD_MIN;
      field_val = disp_min;
      field_ok  = (disp_min <= 6'd59);
    end else if (slot == IW'(2)) begin
      field     = FIELD_HOUR;
      field_val = {1'b0, hour_shown};
      field_ok  = hour_ok;
    end
    bcd = upper ? tens_of(field_val) : ones_of(field_val);
  end

  seg7_decoder u_dec (
    .bcd (bcd),
    .seg (dec_seg)
  );

  // Glyph overrides: blink mask wins over dash, dash wins over leading-zero blank.
  always_comb begin
    glyph = dec_seg;
    if (!field_ok) begin
      glyph = SEG_DASH;
    end else if ((HOUR_LZB != 0) && (field == FIELD_HOUR) && upper && (bcd == 4'd0)) begin
      glyph = SEG_BLANK;
    end
    if (blink_phase && (field != FIELD_NONE) && (edit_field == field)) begin
      glyph = SEG_BLANK;
    end
    dp       = pm && (idx == '0);
    sel_next = NUM_DIGITS'(1) << idx;
  end

  // Register segment and digit drive so they change together, one cycle after the index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg       <= '0;
      digit_sel <= '0;
    end else begin
      seg       <= {dp, glyph};
      digit_sel <= sel_next;
    end
  end

endmodule
